lsu_mem_ctrl: RTL and testbench

- MEM-stage load/store initiator for the pipeline processor. Drives the data memory over a req/ready handshake, with wait-state support.
- Converts pipeline load/store requests (byte/half/word, signed/unsigned) into word-aligned memory accesses with byte enables and lane-replicated write data.
- Stalls the pipeline until each access completes, then returns the extracted and extended load data.

---
 rtl/lsu_mem_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator: turns pipeline loads/stores into word-aligned
// memory accesses over a req/ready handshake and returns extended load data.
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memread_m,
  input  logic                  memwrite_m,
  input  logic [2:0]            funct3_m,
  input  logic [ADDR_WIDTH-1:0] alu_result_m,
  input  logic [DATA_WIDTH-1:0] write_data_m,
  output logic                  stall_m,
  output logic [DATA_WIDTH-1:0] read_data_m,
  output logic                  load_valid_m,
  output logic                  access_fault_m,
  output logic                  bus_err_m,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] LastBusy = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [7:0]            busyCnt_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic                  memReq_q;
  logic                  memWe_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic [3:0]            memBe_q;
  logic [DATA_WIDTH-1:0] readData_q;
  logic                  loadValid_q;
  logic                  fault_q;
  logic                  busErr_q;

  logic                  request;
  logic                  misaligned;
  logic                  unsupported;
  logic                  fault;
  logic                  validReq;
  logic [1:0]            off;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [DATA_WIDTH-1:0] shifted_d;
  logic [DATA_WIDTH-1:0] loadData_d;

  // Request decode: legality, byte lanes and replicated store data.
  always_comb begin
    request     = memread_m | memwrite_m;
    off         = alu_result_m[1:0];
    misaligned  = 1'b0;
    unsupported = 1'b0;
    case (funct3_m)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = off[0];
      3'b010:         misaligned = |off;
      default:        unsupported = 1'b1;
    endcase
    if (memwrite_m && funct3_m[2]) unsupported = 1'b1;
    fault    = request & (misaligned | unsupported);
    validReq = request & ~fault;
    case (funct3_m[1:0])
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{write_data_m[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = write_data_m;
      end
    endcase
  end

  always_comb begin
    shifted_d = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  loadData_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b100:  loadData_d = {24'd0, shifted_d[7:0]};
      3'b001:  loadData_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b101:  loadData_d = {16'd0, shifted_d[15:0]};
      default: loadData_d = shifted_d;
    endcase
  end

  // Gating with rst_n keeps stall low while reset is held even if a request is presented.
  assign stall_m = rst_n & ((state_q == BUSY) | ((state_q == IDLE) & validReq));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busyCnt_q   <= 8'd0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      memReq_q    <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      memBe_q     <= 4'd0;
      readData_q  <= '0;
      loadValid_q <= 1'b0;
      fault_q     <= 1'b0;
      busErr_q    <= 1'b0;
    end else begin
      loadValid_q <= 1'b0;
      fault_q     <= 1'b0;
      busErr_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fault) begin
            fault_q <= 1'b1;
          end else if (validReq) begin
            state_q    <= BUSY;
            busyCnt_q  <= 8'd0;
            memReq_q   <= 1'b1;
            memWe_q    <= memwrite_m;
            memAddr_q  <= {alu_result_m[ADDR_WIDTH-1:2], 2'b00};
            memWdata_q <= wdata_d;
            memBe_q    <= be_d;
            funct3_q   <= funct3_m;
            off_q      <= off;
          end
        end
        BUSY: begin
          busyCnt_q <= busyCnt_q + 8'd1;
          if (mem_ready) begin
            state_q  <= DONE;
            memReq_q <= 1'b0;
            if (!memWe_q) begin
              readData_q  <= loadData_d;
              loadValid_q <= 1'b1;
            end
          end else if (busyCnt_q == LastBusy) begin
            state_q  <= DONE;
            memReq_q <= 1'b0;
            busErr_q <= 1'b1;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          busyCnt_q <= 8'd0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req        = memReq_q;
  assign mem_we         = memWe_q;
  assign mem_addr       = memAddr_q;
  assign mem_wdata      = memWdata_q;
  assign mem_be         = memBe_q;
  assign read_data_m    = readData_q;
  assign load_valid_m   = loadValid_q;
  assign access_fault_m = fault_q;
  assign bus_err_m      = busErr_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed accesses push expected events,
// a monitor pops and compares them as the DUT presents requests and pulses.
module tb_lsu_mem_ctrl;

  localparam int KIND_ACC   = 0;
  localparam int KIND_LOAD  = 1;
  localparam int KIND_FAULT = 2;
  localparam int KIND_BERR  = 3;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        we;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        memread_m;
  logic        memwrite_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m;
  logic [31:0] write_data_m;
  logic        stall_m;
  logic [31:0] read_data_m;
  logic        load_valid_m;
  logic        access_fault_m;
  logic        bus_err_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  exp_t        expQ[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] lastLoad = 32'd0;

  lsu_mem_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .memread_m(memread_m),
    .memwrite_m(memwrite_m),
    .funct3_m(funct3_m),
    .alu_result_m(alu_result_m),
    .write_data_m(write_data_m),
    .stall_m(stall_m),
    .read_data_m(read_data_m),
    .load_valid_m(load_valid_m),
    .access_fault_m(access_fault_m),
    .bus_err_m(bus_err_m),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] be, input logic we);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.be   = be;
    e.we   = we;
    expQ.push_back(e);
  endtask

  // One pipeline access with a memory that answers after 'waits' BUSY cycles.
  task automatic applyStimulus(input string name, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rdata,
                               input int waits, input bit neverReady, input bit expFault,
                               input logic [31:0] expAddr, input logic [3:0] expBe,
                               input logic [31:0] expWdata, input logic [31:0] expLoad,
                               input int expStall, input int expReq);
    int          stallCnt = 0;
    int          reqCnt = 0;
    int          waitCnt = 0;
    bit          unstable = 1'b0;
    bit          done = 1'b0;
    logic [31:0] a0 = 32'd0;
    logic [31:0] wd0 = 32'd0;
    logic [3:0]  be0 = 4'd0;
    logic        we0 = 1'b0;
    if (expFault) begin
      pushExp(KIND_FAULT, 32'd0, 32'd0, 4'd0, 1'b0);
    end else begin
      pushExp(KIND_ACC, expAddr, expWdata, expBe, wr);
      if (neverReady) pushExp(KIND_BERR, 32'd0, 32'd0, 4'd0, 1'b0);
      else if (rd && !wr) pushExp(KIND_LOAD, 32'd0, expLoad, 4'd0, 1'b0);
    end
    @(negedge clk);
    memread_m    = rd;
    memwrite_m   = wr;
    funct3_m     = f3;
    alu_result_m = addr;
    write_data_m = wd;
    mem_rdata    = rdata;
    mem_ready    = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (stall_m) stallCnt++;
      if (mem_req) begin
        if (reqCnt == 0) begin
          a0  = mem_addr;
          be0 = mem_be;
          wd0 = mem_wdata;
          we0 = mem_we;
        end else if (mem_addr !== a0 || mem_be !== be0 || mem_wdata !== wd0 || mem_we !== we0) begin
          unstable = 1'b1;
        end
        reqCnt++;
        mem_ready = !neverReady && (waitCnt >= waits);
        waitCnt++;
      end else begin
        mem_ready = 1'b0;
      end
      if (cyc > 0 && !stall_m) done = 1'b1;
    end
    memread_m  = 1'b0;
    memwrite_m = 1'b0;
    mem_ready  = 1'b0;
    checkOutput({name, " completed"}, 32'(done), 32'd1);
    checkOutput({name, " stall cycles"}, 32'(stallCnt), 32'(expStall));
    checkOutput({name, " req cycles"}, 32'(reqCnt), 32'(expReq));
    checkOutput({name, " mem stable"}, 32'(unstable), 32'd0);
    if (neverReady) checkOutput({name, " rdata held"}, read_data_m, lastLoad);
    else if (rd && !wr && !expFault) lastLoad = expLoad;
  endtask

  // Monitor: pops an expectation whenever a request starts or a pulse appears.
  initial begin : monitor
    logic prevReq;
    exp_t e;
    prevReq = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevReq = 1'b0;
      end else begin
        if (mem_req && !prevReq) begin
          checkOutput("acc expected", 32'(expQ.size() > 0), 32'd1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("acc kind", 32'(KIND_ACC), 32'(e.kind));
            checkOutput("mem_addr", mem_addr, e.addr);
            checkOutput("mem_we", 32'(mem_we), 32'(e.we));
            checkOutput("mem_be", 32'(mem_be), 32'(e.be));
            if (e.we) checkOutput("mem_wdata", mem_wdata, e.data);
          end
        end
        if (load_valid_m || access_fault_m || bus_err_m) begin
          checkOutput("pulse onehot", 32'($countones({load_valid_m, access_fault_m, bus_err_m})), 32'd1);
          checkOutput("pulse expected", 32'(expQ.size() > 0), 32'd1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            if (load_valid_m) begin
              checkOutput("load kind", 32'(KIND_LOAD), 32'(e.kind));
              checkOutput("read_data_m", read_data_m, e.data);
            end else if (access_fault_m) begin
              checkOutput("fault kind", 32'(KIND_FAULT), 32'(e.kind));
            end else begin
              checkOutput("bus_err kind", 32'(KIND_BERR), 32'(e.kind));
            end
          end
        end
        prevReq = mem_req;
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    memread_m    = 1'b0;
    memwrite_m   = 1'b0;
    funct3_m     = 3'd0;
    alu_result_m = 32'd0;
    write_data_m = 32'd0;
    mem_ready    = 1'b0;
    mem_rdata    = 32'd0;
    #2;
    checkOutput("reset stall", 32'(stall_m), 32'd0);
    checkOutput("reset req", 32'(mem_req), 32'd0);
    checkOutput("reset pulses", 32'({load_valid_m, access_fault_m, bus_err_m}), 32'd0);
    checkOutput("reset rdata", read_data_m, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("SW", 0, 1, 3'b010, 32'h0C70F264, 32'h0C70F26F, 32'h0, 0, 0, 0,
                  32'h0C70F264, 4'b1111, 32'h0C70F26F, 32'h0, 2, 1);
    applyStimulus("LBU", 1, 0, 3'b100, 32'h0C70F262, 32'h0, 32'hA1B2C3D4, 0, 0, 0,
                  32'h0C70F260, 4'b0100, 32'h0, 32'h000000B2, 2, 1);
    applyStimulus("LB", 1, 0, 3'b000, 32'h0C70F263, 32'h0, 32'hA1B2C3D4, 0, 0, 0,
                  32'h0C70F260, 4'b1000, 32'h0, 32'hFFFFFFA1, 2, 1);
    applyStimulus("LH", 1, 0, 3'b001, 32'h0C70F260, 32'h0, 32'hA1B2C3D4, 0, 0, 0,
                  32'h0C70F260, 4'b0011, 32'h0, 32'hFFFFC3D4, 2, 1);
    applyStimulus("LHU", 1, 0, 3'b101, 32'h0C70F262, 32'h0, 32'hA1B2C3D4, 0, 0, 0,
                  32'h0C70F260, 4'b1100, 32'h0, 32'h0000A1B2, 2, 1);
    applyStimulus("SH", 0, 1, 3'b001, 32'h0C70F262, 32'h1234BEEF, 32'h0, 0, 0, 0,
                  32'h0C70F260, 4'b1100, 32'hBEEFBEEF, 32'h0, 2, 1);
    applyStimulus("SB", 0, 1, 3'b000, 32'h0C70F261, 32'h000000A5, 32'h0, 0, 0, 0,
                  32'h0C70F260, 4'b0010, 32'hA5A5A5A5, 32'h0, 2, 1);
    applyStimulus("RW both", 1, 1, 3'b010, 32'h0C70F26C, 32'h55AA55AA, 32'h0, 0, 0, 0,
                  32'h0C70F26C, 4'b1111, 32'h55AA55AA, 32'h0, 2, 1);
    applyStimulus("LH misaligned", 1, 0, 3'b001, 32'h0C70F261, 32'h0, 32'h0, 0, 0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus("LW misaligned", 1, 0, 3'b010, 32'h0C70F262, 32'h0, 32'h0, 0, 0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus("funct3 011", 1, 0, 3'b011, 32'h0C70F260, 32'h0, 32'h0, 0, 0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus("store 100", 0, 1, 3'b100, 32'h0C70F260, 32'h11, 32'h0, 0, 0, 1,
                  32'h0, 4'h0, 32'h0, 32'h0, 0, 0);
    applyStimulus("LW 3 waits", 1, 0, 3'b010, 32'h0C70F264, 32'h0, 32'h13579BDF, 3, 0, 0,
                  32'h0C70F264, 4'b1111, 32'h0, 32'h13579BDF, 5, 4);
    applyStimulus("LW last cycle", 1, 0, 3'b010, 32'h0C70F268, 32'h0, 32'h2468ACE0, 15, 0, 0,
                  32'h0C70F268, 4'b1111, 32'h0, 32'h2468ACE0, 17, 16);
    applyStimulus("LW timeout", 1, 0, 3'b010, 32'h0C70F268, 32'h0, 32'hFFFFFFFF, 0, 1, 0,
                  32'h0C70F268, 4'b1111, 32'h0, 32'h0, 17, 16);

    // Reset in the middle of a store that memory never answers.
    pushExp(KIND_ACC, 32'h0C70F270, 32'hDEADBEEF, 4'b1111, 1'b1);
    @(negedge clk);
    memwrite_m   = 1'b1;
    funct3_m     = 3'b010;
    alu_result_m = 32'h0C70F270;
    write_data_m = 32'hDEADBEEF;
    mem_ready    = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("pre-reset req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid reset req", 32'(mem_req), 32'd0);
    checkOutput("mid reset stall", 32'(stall_m), 32'd0);
    checkOutput("mid reset mem bus", 32'({mem_we, mem_be}) | mem_addr | mem_wdata, 32'd0);
    checkOutput("mid reset rdata", read_data_m, 32'd0);
    memwrite_m = 1'b0;
    lastLoad   = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("LW after reset", 1, 0, 3'b010, 32'h0C70F260, 32'h0, 32'hCAFEF00D, 0, 0, 0,
                  32'h0C70F260, 4'b1111, 32'h0, 32'hCAFEF00D, 2, 1);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
